pool_mem_arbiter: RTL and testbench

- Shares the single memory port between the `PROC_COUNT` processors of the processor pool.
- Collects per-processor read and write requests and picks one winner round-robin, granting it and driving the memory command from that processor's address, data and size.
- For reads, returns a one-cycle valid pulse to the winner when memory read data is on the shared pool data bus.
- Sits between the pool outputs (req/addr/data/size) and the pool inputs (grant_rd, grant_wr, valid).

---
 rtl/pool_mem_arbiter_pkg.sv | 22 ++
 rtl/pool_mem_arbiter_rr_pick.sv | 33 +++
 rtl/pool_mem_arbiter.sv | 130 +++++++++++++
 tb/tb_pool_mem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pool_mem_arbiter_pkg.sv
// Shared types and constants for the pool memory arbiter and its
// round-robin picker.
package pool_mem_arbiter_pkg;

   localparam int PROC_COUNT  = 4;
   localparam int ADDR_W      = 16;
   localparam int DATA_W      = 128;
   localparam int WR_SIZE_W   = 3;
   localparam int MEM_LAT_DEF = 2;
   localparam int IDX_W       = (PROC_COUNT > 1) ? $clog2(PROC_COUNT) : 1;
   localparam int CNT_W       = 8;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [IDX_W-1:0]  idx_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      RD_WAIT
   } arb_state_t;

endpackage

// File: rtl/pool_mem_arbiter_rr_pick.sv
// Combinational round-robin selector: returns the first set request bit
// strictly after ptr, wrapping modulo N, so ptr itself has lowest priority.
module pool_mem_arbiter_rr_pick
   import pool_mem_arbiter_pkg::*;
#(
   parameter int N  = PROC_COUNT,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          valid,
   output logic [IW-1:0] idx
);

   int            pos;
   logic [IW-1:0] sel;

   always_comb begin
      valid = 1'b0;
      idx   = '0;
      pos   = 0;
      sel   = '0;
      for (int i = 1; i <= N; i++) begin
         pos = (int'(ptr) + i) % N;
         sel = IW'(pos);
         if (!valid && req[sel]) begin
            valid = 1'b1;
            idx   = sel;
         end
      end
   end

endmodule

// File: rtl/pool_mem_arbiter.sv
// Shares one memory port between the pool processors: round-robin pick,
// one-cycle issue with grant pulse, and a read-data valid pulse MEM_LAT later.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for any request; picks and registers the winner
// ISSUE   | one cycle: grant + mem strobe if request still held, else abort
// RD_WAIT | counting down read latency; pulses o_valid at terminal count
module pool_mem_arbiter
   import pool_mem_arbiter_pkg::*;
#(
   parameter int MEM_LAT = MEM_LAT_DEF
) (
   input  logic                                 i_clk,
   input  logic                                 i_rstn,
   input  logic [PROC_COUNT-1:0]                i_req_rd,
   input  logic [PROC_COUNT-1:0]                i_req_wr,
   input  addr_t [PROC_COUNT-1:0]               i_addr,
   input  logic [PROC_COUNT-1:0][DATA_W-1:0]    i_data,
   input  logic [PROC_COUNT-1:0][WR_SIZE_W-1:0] i_wr_size,
   output logic [PROC_COUNT-1:0]                o_grant_rd,
   output logic [PROC_COUNT-1:0]                o_grant_wr,
   output logic [PROC_COUNT-1:0]                o_valid,
   output logic                                 o_mem_en,
   output logic                                 o_mem_we,
   output addr_t                                o_mem_addr,
   output logic [DATA_W-1:0]                    o_mem_wdata,
   output logic [WR_SIZE_W-1:0]                 o_mem_wsize,
   output logic                                 o_busy
);

   arb_state_t       state_q, state_d;
   idx_t             win_idx_q, win_idx_d;
   logic             win_we_q, win_we_d;
   idx_t             ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [PROC_COUNT-1:0] req_any;
   logic                  pick_valid;
   idx_t                  pick_idx;
   logic                  req_sel;

   assign req_any = i_req_rd | i_req_wr;
   assign req_sel = win_we_q ? i_req_wr[win_idx_q] : i_req_rd[win_idx_q];
   assign o_busy  = (state_q != IDLE);

   pool_mem_arbiter_rr_pick #(
      .N  (PROC_COUNT),
      .IW (IDX_W)
   ) u_rr_pick (
      .req   (req_any),
      .ptr   (ptr_q),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q   <= IDLE;
         win_idx_q <= '0;
         win_we_q  <= 1'b0;
         ptr_q     <= idx_t'(PROC_COUNT - 1);
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         win_idx_q <= win_idx_d;
         win_we_q  <= win_we_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      win_idx_d   = win_idx_q;
      win_we_d    = win_we_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      o_grant_rd  = '0;
      o_grant_wr  = '0;
      o_valid     = '0;
      o_mem_en    = 1'b0;
      o_mem_we    = 1'b0;
      o_mem_addr  = '0;
      o_mem_wdata = '0;
      o_mem_wsize = '0;

      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               win_idx_d = pick_idx;
               // write wins when a proc holds both requests
               win_we_d  = i_req_wr[pick_idx];
               state_d   = ISSUE;
            end
         end

         ISSUE: begin
            state_d = IDLE;
            if (req_sel) begin
               if (win_we_q) begin
                  o_grant_wr[win_idx_q] = 1'b1;
               end else begin
                  o_grant_rd[win_idx_q] = 1'b1;
                  cnt_d   = CNT_W'(MEM_LAT - 1);
                  state_d = RD_WAIT;
               end
               o_mem_en    = 1'b1;
               o_mem_we    = win_we_q;
               o_mem_addr  = i_addr[win_idx_q];
               o_mem_wdata = i_data[win_idx_q];
               o_mem_wsize = i_wr_size[win_idx_q];
               ptr_d       = win_idx_q;
            end
         end

         RD_WAIT: begin
            if (cnt_q == '0) begin
               o_valid[win_idx_q] = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_pool_mem_arbiter.sv
// Directed bench for pool_mem_arbiter: stimulus pushes expected output
// events with their cycle into a queue, a negedge monitor pops and compares.
module tb_pool_mem_arbiter;
   import pool_mem_arbiter_pkg::*;

   localparam int N = PROC_COUNT;

   localparam addr_t A0 = 16'h0040;
   localparam addr_t A1 = 16'h1100;
   localparam addr_t A2 = 16'h1234;
   localparam addr_t A3 = 16'h3300;
   localparam logic [127:0] D0 = 128'h00000000_11111111_22222222_33333333;
   localparam logic [127:0] D1 = 128'h44444444_55555555_66666666_77777777;
   localparam logic [127:0] D2 = 128'h88888888_99999999_aaaaaaaa_bbbbbbbb;
   localparam logic [127:0] D3 = 128'hcccccccc_dddddddd_eeeeeeee_ffffffff;
   localparam logic [2:0] S0 = 3'd1;
   localparam logic [2:0] S1 = 3'd2;
   localparam logic [2:0] S2 = 3'd4;
   localparam logic [2:0] S3 = 3'd7;

   logic                                 i_clk = 1'b0;
   logic                                 i_rstn = 1'b0;
   logic [N-1:0]                         i_req_rd = '0;
   logic [N-1:0]                         i_req_wr = '0;
   addr_t [N-1:0]                        i_addr;
   logic [N-1:0][DATA_W-1:0]             i_data;
   logic [N-1:0][WR_SIZE_W-1:0]          i_wr_size;
   logic [N-1:0]                         o_grant_rd;
   logic [N-1:0]                         o_grant_wr;
   logic [N-1:0]                         o_valid;
   logic                                 o_mem_en;
   logic                                 o_mem_we;
   addr_t                                o_mem_addr;
   logic [DATA_W-1:0]                    o_mem_wdata;
   logic [WR_SIZE_W-1:0]                 o_mem_wsize;
   logic                                 o_busy;

   pool_mem_arbiter #(.MEM_LAT(2)) dut (
      .i_clk       (i_clk),
      .i_rstn      (i_rstn),
      .i_req_rd    (i_req_rd),
      .i_req_wr    (i_req_wr),
      .i_addr      (i_addr),
      .i_data      (i_data),
      .i_wr_size   (i_wr_size),
      .o_grant_rd  (o_grant_rd),
      .o_grant_wr  (o_grant_wr),
      .o_valid     (o_valid),
      .o_mem_en    (o_mem_en),
      .o_mem_we    (o_mem_we),
      .o_mem_addr  (o_mem_addr),
      .o_mem_wdata (o_mem_wdata),
      .o_mem_wsize (o_mem_wsize),
      .o_busy      (o_busy)
   );

   always #5 i_clk = ~i_clk;

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;
   bit sb_on = 1'b1;

   typedef struct {
      int           cyc;
      logic [3:0]   g_rd;
      logic [3:0]   g_wr;
      logic [3:0]   vld;
      logic         en;
      logic         we;
      addr_t        addr;
      logic [127:0] data;
      logic [2:0]   size;
   } ev_t;

   ev_t exp_q[$];

   function automatic ev_t mk(int c, logic [3:0] grd, logic [3:0] gwr, logic [3:0] v,
                              logic en, logic we, addr_t a, logic [127:0] d, logic [2:0] s);
      ev_t e;
      e.cyc = c; e.g_rd = grd; e.g_wr = gwr; e.vld = v;
      e.en = en; e.we = we; e.addr = a; e.data = d; e.size = s;
      return e;
   endfunction

   task automatic wait_cyc(int n);
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   task automatic check_idle_outputs(string name);
      checks++;
      if (o_grant_rd !== '0 || o_grant_wr !== '0 || o_valid !== '0 || o_mem_en !== 1'b0 ||
          o_mem_we !== 1'b0 || o_mem_addr !== '0 || o_mem_wdata !== '0 ||
          o_mem_wsize !== '0 || o_busy !== 1'b0) begin
         failures++;
         $display("FAIL %s: got rd=%b wr=%b v=%b en=%b we=%b a=%h s=%0d busy=%b, want all zero",
                  name, o_grant_rd, o_grant_wr, o_valid, o_mem_en, o_mem_we, o_mem_addr,
                  o_mem_wsize, o_busy);
      end
   endtask

   task automatic check_bit(string name, logic got, logic want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %b want %b", name, got, want);
      end
   endtask

   task automatic do_reset();
      i_rstn   = 1'b0;
      i_req_rd = '0;
      i_req_wr = '0;
      wait_cyc(2);
      check_idle_outputs("reset_state");
      i_rstn = 1'b1;
   endtask

   // monitor: pops one expected event whenever the DUT shows any pulse
   ev_t e;
   always @(negedge i_clk) begin
      if (i_rstn) begin
         checks++;
         if (!$onehot0(o_grant_rd | o_grant_wr | o_valid)) begin
            failures++;
            $display("FAIL onehot@%0d: got rd=%b wr=%b v=%b, want at most one bit",
                     cyc, o_grant_rd, o_grant_wr, o_valid);
         end
         if (!o_mem_en) begin
            checks++;
            if (o_mem_addr !== '0 || o_mem_wdata !== '0 || o_mem_wsize !== '0 || o_mem_we !== 1'b0) begin
               failures++;
               $display("FAIL mem_idle_zero@%0d: got we=%b a=%h s=%0d, want zero",
                        cyc, o_mem_we, o_mem_addr, o_mem_wsize);
            end
         end
         if (sb_on) begin
            if ((o_grant_rd | o_grant_wr | o_valid) != '0 || o_mem_en) begin
               checks++;
               if (exp_q.size() == 0) begin
                  failures++;
                  $display("FAIL unexpected@%0d: got rd=%b wr=%b v=%b en=%b, want nothing",
                           cyc, o_grant_rd, o_grant_wr, o_valid, o_mem_en);
               end else begin
                  e = exp_q.pop_front();
                  if (cyc != e.cyc || o_grant_rd !== e.g_rd || o_grant_wr !== e.g_wr ||
                      o_valid !== e.vld || o_mem_en !== e.en || o_mem_we !== e.we ||
                      o_mem_addr !== e.addr || o_mem_wdata !== e.data || o_mem_wsize !== e.size) begin
                     failures++;
                     $display("FAIL event: got cyc=%0d rd=%b wr=%b v=%b en=%b we=%b a=%h d=%h s=%0d; want cyc=%0d rd=%b wr=%b v=%b en=%b we=%b a=%h d=%h s=%0d",
                              cyc, o_grant_rd, o_grant_wr, o_valid, o_mem_en, o_mem_we,
                              o_mem_addr, o_mem_wdata, o_mem_wsize,
                              e.cyc, e.g_rd, e.g_wr, e.vld, e.en, e.we, e.addr, e.data, e.size);
                  end
               end
            end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
               checks++;
               failures++;
               $display("FAIL missing_event: got nothing by cyc=%0d, want rd=%b wr=%b v=%b at cyc=%0d",
                        cyc, exp_q[0].g_rd, exp_q[0].g_wr, exp_q[0].vld, exp_q[0].cyc);
               void'(exp_q.pop_front());
            end
         end
      end
   end

   a_onehot: assert property (@(negedge i_clk) disable iff (!i_rstn)
                              $onehot0(o_grant_rd | o_grant_wr | o_valid))
      else begin
         failures++;
         $display("FAIL a_onehot: got rd=%b wr=%b v=%b", o_grant_rd, o_grant_wr, o_valid);
      end

   int n;
   int m;

   initial begin
      i_addr    = {A3, A2, A1, A0};
      i_data    = {D3, D2, D1, D0};
      i_wr_size = {S3, S2, S1, S0};

      // 1: single read from proc 0
      do_reset();
      n = cyc;
      i_req_rd = 4'b0001;
      exp_q.push_back(mk(n + 1, 4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b0, A0, D0, S0));
      exp_q.push_back(mk(n + 3, 4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b0, '0, '0, '0));
      wait_cyc(2);
      check_bit("t1_busy_rd_wait", o_busy, 1'b1);
      i_req_rd = '0;
      wait_cyc(2);
      check_bit("t1_busy_after", o_busy, 1'b0);

      // 2: all four write continuously, rotation 0,1,2,3,0
      do_reset();
      n = cyc;
      i_req_wr = 4'b1111;
      exp_q.push_back(mk(n + 1, 4'b0000, 4'b0001, 4'b0000, 1'b1, 1'b1, A0, D0, S0));
      exp_q.push_back(mk(n + 3, 4'b0000, 4'b0010, 4'b0000, 1'b1, 1'b1, A1, D1, S1));
      exp_q.push_back(mk(n + 5, 4'b0000, 4'b0100, 4'b0000, 1'b1, 1'b1, A2, D2, S2));
      exp_q.push_back(mk(n + 7, 4'b0000, 4'b1000, 4'b0000, 1'b1, 1'b1, A3, D3, S3));
      exp_q.push_back(mk(n + 9, 4'b0000, 4'b0001, 4'b0000, 1'b1, 1'b1, A0, D0, S0));
      wait_cyc(10);
      i_req_wr = '0;
      wait_cyc(3);
      check_bit("t2_busy_after", o_busy, 1'b0);

      // 3: proc 2 with read and write: write first, then read
      do_reset();
      n = cyc;
      i_req_rd = 4'b0100;
      i_req_wr = 4'b0100;
      exp_q.push_back(mk(n + 1, 4'b0000, 4'b0100, 4'b0000, 1'b1, 1'b1, A2, D2, S2));
      exp_q.push_back(mk(n + 3, 4'b0100, 4'b0000, 4'b0000, 1'b1, 1'b0, A2, D2, S2));
      exp_q.push_back(mk(n + 5, 4'b0000, 4'b0000, 4'b0100, 1'b0, 1'b0, '0, '0, '0));
      wait_cyc(2);
      i_req_wr = '0;
      wait_cyc(2);
      i_req_rd = '0;
      wait_cyc(3);

      // 4: proc 1 aborts during ISSUE, proc 3 follows
      do_reset();
      n = cyc;
      i_req_rd = 4'b0010;
      wait_cyc(1);
      i_req_rd = '0;
      #1;
      check_bit("t4_abort_no_en", o_mem_en, 1'b0);
      check_bit("t4_abort_busy", o_busy, 1'b1);
      wait_cyc(1);
      i_req_rd = 4'b1000;
      exp_q.push_back(mk(n + 3, 4'b1000, 4'b0000, 4'b0000, 1'b1, 1'b0, A3, D3, S3));
      exp_q.push_back(mk(n + 5, 4'b0000, 4'b0000, 4'b1000, 1'b0, 1'b0, '0, '0, '0));
      wait_cyc(2);
      i_req_rd = '0;
      wait_cyc(3);

      // 5: reset during RD_WAIT drops the read; then proc 0 beats proc 3
      do_reset();
      n = cyc;
      i_req_rd = 4'b1000;
      exp_q.push_back(mk(n + 1, 4'b1000, 4'b0000, 4'b0000, 1'b1, 1'b0, A3, D3, S3));
      wait_cyc(2);
      i_req_rd = '0;
      i_rstn = 1'b0;
      #1;
      check_idle_outputs("t5_reset_mid_read");
      wait_cyc(2);
      i_rstn = 1'b1;
      m = cyc;
      i_req_rd = 4'b1001;
      exp_q.push_back(mk(m + 1, 4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b0, A0, D0, S0));
      exp_q.push_back(mk(m + 3, 4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b0, '0, '0, '0));
      exp_q.push_back(mk(m + 5, 4'b1000, 4'b0000, 4'b0000, 1'b1, 1'b0, A3, D3, S3));
      exp_q.push_back(mk(m + 7, 4'b0000, 4'b0000, 4'b1000, 1'b0, 1'b0, '0, '0, '0));
      wait_cyc(2);
      i_req_rd = 4'b1000;
      wait_cyc(4);
      i_req_rd = '0;
      wait_cyc(3);

      // 6: random rd on proc 0 / wr on proc 1, exclusivity only
      do_reset();
      sb_on = 1'b0;
      for (int k = 0; k < 1000; k++) begin
         i_req_rd[0] = 1'($urandom_range(0, 1));
         i_req_wr[1] = 1'($urandom_range(0, 1));
         wait_cyc(1);
      end
      i_req_rd = '0;
      i_req_wr = '0;
      wait_cyc(5);
      sb_on = 1'b1;
      check_bit("t6_busy_after", o_busy, 1'b0);

      wait_cyc(2);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL leftover_events: got %0d pending, want 0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
